// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_imem_loader
//  Purpose  : Boot-time loader. Assembles UART bytes (LSB first) into 32-bit
//             instruction words and writes them to consecutive instruction
//             memory addresses while holding the CPU core in reset. Loading
//             ends on the terminator word 32'hFFFFFFFF or when memory fills;
//             the core is then released.
//  Ports    : clk, rst        - clock (rising edge), async active-high reset
//             rx_valid/rx_data- one-cycle strobe with received byte
//             rx_break        - UART BREAK level, restarts the load
//             imem_we/addr/wdata - one-cycle instruction memory write
//             cpu_rst         - core reset, high until loading completes
//             write_done      - sticky load-complete flag
//             word_count      - words written so far (0..MAX_WORDS)
//             overflow        - sticky, load stopped because memory filled
//             sync_err        - sticky, a partial word was dropped by timeout
//  Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int MAX_WORDS   = 256,
    parameter int TIMEOUT_CYC = 104170
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              write_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              sync_err
);

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_WRITE   = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    localparam int                 c_TMO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_LAST  = ADDR_W'(MAX_WORDS - 1);
    localparam logic [31:0]        c_TERMINATOR = 32'hFFFF_FFFF;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [1:0]         r_byte_idx,   w_byte_idx_nxt;
    logic [31:0]        r_word,       w_word_nxt;
    logic [31:0]        w_word_ins;
    logic [ADDR_W-1:0]  r_addr,       w_addr_nxt;
    logic [c_TMO_W-1:0] r_tmo,        w_tmo_nxt;

    logic               r_imem_we,    w_imem_we_nxt;
    logic [ADDR_W-1:0]  r_imem_addr,  w_imem_addr_nxt;
    logic [31:0]        r_imem_wdata, w_imem_wdata_nxt;
    logic               r_cpu_rst,    w_cpu_rst_nxt;
    logic               r_done,       w_done_nxt;
    logic [ADDR_W:0]    r_count,      w_count_nxt;
    logic               r_overflow,   w_overflow_nxt;
    logic               r_sync_err,   w_sync_err_nxt;

    // Current word with the incoming byte dropped into its lane; the write
    // strobe is registered on the 4th byte, so the terminator test must see
    // the complete word including the byte arriving this cycle.
    always_comb begin
        w_word_ins = r_word;
        case (r_byte_idx)
            2'd0: w_word_ins[7:0]   = rx_data;
            2'd1: w_word_ins[15:8]  = rx_data;
            2'd2: w_word_ins[23:16] = rx_data;
            2'd3: w_word_ins[31:24] = rx_data;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_COLLECT: begin
                if (!rx_break && rx_valid && (r_byte_idx == 2'd3)) begin
                    w_state_nxt = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                if (rx_break) begin
                    w_state_nxt = c_ST_COLLECT;
                end else if ((r_word == c_TERMINATOR) || (r_addr == c_ADDR_LAST)) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_state_nxt = c_ST_COLLECT;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values (all outputs are registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_byte_idx_nxt   = r_byte_idx;
        w_word_nxt       = r_word;
        w_addr_nxt       = r_addr;
        w_tmo_nxt        = r_tmo;
        w_imem_we_nxt    = 1'b0;
        w_imem_addr_nxt  = r_imem_addr;
        w_imem_wdata_nxt = r_imem_wdata;
        w_cpu_rst_nxt    = r_cpu_rst;
        w_done_nxt       = r_done;
        w_count_nxt      = r_count;
        w_overflow_nxt   = r_overflow;
        w_sync_err_nxt   = r_sync_err;

        case (r_state)
            c_ST_COLLECT: begin
                if (rx_break) begin
                    // Break wins over a coincident byte; sticky flags survive.
                    w_byte_idx_nxt = 2'd0;
                    w_addr_nxt     = '0;
                    w_count_nxt    = '0;
                    w_tmo_nxt      = '0;
                end else if (rx_valid) begin
                    w_word_nxt     = w_word_ins;
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    w_tmo_nxt      = '0;
                    if (r_byte_idx == 2'd3) begin
                        w_imem_we_nxt    = (w_word_ins != c_TERMINATOR);
                        w_imem_addr_nxt  = r_addr;
                        w_imem_wdata_nxt = w_word_ins;
                    end
                end else if (r_byte_idx != 2'd0) begin
                    if (r_tmo == c_TMO_LAST) begin
                        w_byte_idx_nxt = 2'd0;
                        w_tmo_nxt      = '0;
                        w_sync_err_nxt = 1'b1;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
            end
            c_ST_WRITE: begin
                if (rx_break) begin
                    w_byte_idx_nxt = 2'd0;
                    w_addr_nxt     = '0;
                    w_count_nxt    = '0;
                    w_tmo_nxt      = '0;
                end else if (r_word == c_TERMINATOR) begin
                    w_done_nxt    = 1'b1;
                    w_cpu_rst_nxt = 1'b0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                    if (r_addr == c_ADDR_LAST) begin
                        // Address is held at the last slot so it never wraps.
                        w_overflow_nxt = 1'b1;
                        w_done_nxt     = 1'b1;
                        w_cpu_rst_nxt  = 1'b0;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
            default: begin
                // DONE: everything frozen until reset.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx   <= 2'd0;
            r_word       <= '0;
            r_addr       <= '0;
            r_tmo        <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_byte_idx   <= w_byte_idx_nxt;
            r_word       <= w_word_nxt;
            r_addr       <= w_addr_nxt;
            r_tmo        <= w_tmo_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_wdata <= w_imem_wdata_nxt;
            r_cpu_rst    <= w_cpu_rst_nxt;
            r_done       <= w_done_nxt;
            r_count      <= w_count_nxt;
            r_overflow   <= w_overflow_nxt;
            r_sync_err   <= w_sync_err_nxt;
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign write_done = r_done;
    assign word_count = r_count;
    assign overflow   = r_overflow;
    assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_imem_loader
//  Purpose  : Self-checking bench for uart_imem_loader. A queue-based model
//             tracks the byte stream and predicts every registered output;
//             directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_imem_loader;

    localparam int P_ADDR_W = 3;
    localparam int P_MAX    = 8;
    localparam int P_TMO    = 40;

    logic                clk      = 1'b0;
    logic                rst      = 1'b1;
    logic                rx_valid = 1'b0;
    logic [7:0]          rx_data  = 8'h00;
    logic                rx_break = 1'b0;
    logic                imem_we;
    logic [P_ADDR_W-1:0] imem_addr;
    logic [31:0]         imem_wdata;
    logic                cpu_rst;
    logic                write_done;
    logic [P_ADDR_W:0]   word_count;
    logic                overflow;
    logic                sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_imem_loader #(
        .ADDR_W     (P_ADDR_W),
        .MAX_WORDS  (P_MAX),
        .TIMEOUT_CYC(P_TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_break  (rx_break),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst   (cpu_rst),
        .write_done(write_done),
        .word_count(word_count),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: pending bytes in a queue, idle cycles counted
    // while a partial word exists, expected outputs after each edge.
    // ------------------------------------------------------------------
    logic [7:0]  m_q[$];
    int          m_idle     = 0;
    bit          m_in_write = 1'b0;
    bit          m_was_write;
    logic [31:0] m_word     = '0;
    int          m_addr     = 0;
    int          m_count    = 0;
    bit          m_done     = 1'b0;
    bit          m_ovf      = 1'b0;
    bit          m_sync     = 1'b0;
    bit          m_we       = 1'b0;
    int          m_we_addr  = 0;
    logic [31:0] m_we_data  = '0;

    task automatic model_reset();
        m_q.delete();
        m_idle     = 0;
        m_in_write = 1'b0;
        m_addr     = 0;
        m_count    = 0;
        m_done     = 1'b0;
        m_ovf      = 1'b0;
        m_sync     = 1'b0;
        m_we       = 1'b0;
    endtask

    task automatic model_restart();
        m_q.delete();
        m_addr  = 0;
        m_count = 0;
        m_idle  = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            m_was_write = m_in_write;
            m_in_write  = 1'b0;
            m_we        = 1'b0;
            if (m_done) begin
                // loader finished: input ignored
            end else if (m_was_write) begin
                if (rx_break) begin
                    model_restart();
                end else if (m_word == 32'hFFFF_FFFF) begin
                    m_done = 1'b1;
                end else begin
                    m_count++;
                    if (m_addr == P_MAX - 1) begin
                        m_ovf  = 1'b1;
                        m_done = 1'b1;
                    end else begin
                        m_addr++;
                    end
                end
            end else if (rx_break) begin
                model_restart();
            end else if (rx_valid) begin
                m_q.push_back(rx_data);
                m_idle = 0;
                if (m_q.size() == 4) begin
                    m_word     = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_q.delete();
                    m_in_write = 1'b1;
                    m_we       = (m_word != 32'hFFFF_FFFF);
                    m_we_addr  = m_addr;
                    m_we_data  = m_word;
                end
            end else if (m_q.size() != 0) begin
                m_idle++;
                if (m_idle == P_TMO) begin
                    m_q.delete();
                    m_idle = 0;
                    m_sync = 1'b1;
                end
            end
        end
    end

    // Compare process: every output, every cycle, just after the edge.
    always @(posedge clk) begin
        #1;
        check("imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
            check("imem_addr", 32'(imem_addr), 32'(m_we_addr));
            check("imem_wdata", imem_wdata, m_we_data);
        end
        check("cpu_rst", 32'(cpu_rst), 32'(!m_done));
        check("write_done", 32'(write_done), 32'(m_done));
        check("word_count", 32'(word_count), 32'(m_count));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("sync_err", 32'(sync_err), 32'(m_sync));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge; gap >= 1 keeps
    // every new action out of the write cycle that follows a 4th byte)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] d, input int gap);
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic send_break(input int gap, input bit with_byte, input logic [7:0] d);
        repeat (gap) @(negedge clk);
        rx_break = 1'b1;
        rx_valid = with_byte;
        rx_data  = d;
        @(negedge clk);
        rx_break = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] t2 [3];
    logic [31:0] w;
    int          kind;
    int          bpos;
    int          sel;
    int          gap;
    int          r;
    logic [7:0]  d;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_write_done", 32'(write_done), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        rst = 1'b0;

        // Single word then terminator
        send_word(32'hFE01_0113, 2);
        check("t1_we", 32'(imem_we), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'd0);
        check("t1_wdata", imem_wdata, 32'hFE01_0113);
        send_word(32'hFFFF_FFFF, 2);
        check("t1_term_no_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        check("t1_done", 32'(write_done), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1_count", 32'(word_count), 32'd1);

        // Three words in order, terminator not written
        do_reset();
        t2 = '{32'h0081_2E23, 32'h0201_0413, 32'h001F_7793};
        for (int i = 0; i < 3; i++) begin
            send_word(t2[i], 1 + i);
            check("t2_we", 32'(imem_we), 32'd1);
            check("t2_addr", 32'(imem_addr), 32'(i));
            check("t2_wdata", imem_wdata, t2[i]);
        end
        send_word(32'hFFFF_FF00, 1);
        check("t2_nearterm_we", 32'(imem_we), 32'd1);
        check("t2_nearterm_addr", 32'(imem_addr), 32'd3);
        send_word(32'hFFFF_FFFF, 3);
        check("t2_term_no_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        check("t2_count", 32'(word_count), 32'd4);
        check("t2_done", 32'(write_done), 32'd1);

        // Gap of one cycle short of the timeout keeps the partial word
        do_reset();
        send_byte(8'h01, 1);
        send_byte(8'h02, P_TMO - 1);
        send_byte(8'h03, 1);
        send_byte(8'h04, 1);
        check("t3a_wdata", imem_wdata, 32'h0403_0201);
        check("t3a_sync", 32'(sync_err), 32'd0);

        // Full timeout drops the partial word
        do_reset();
        send_byte(8'h93, 1);
        send_byte(8'h77, 2);
        send_byte(8'h33, P_TMO);
        check("t3_sync", 32'(sync_err), 32'd1);
        send_byte(8'h7F, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h00, 1);
        check("t3_we", 32'(imem_we), 32'd1);
        check("t3_addr", 32'(imem_addr), 32'd0);
        check("t3_wdata", imem_wdata, 32'h00FF_7F33);

        // Break mid-word after two writes restarts at address 0
        do_reset();
        send_word(32'h1111_2222, 1);
        send_word(32'h3333_4444, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_break(3, 1'b0, 8'h00);
        check("t4_count_cleared", 32'(word_count), 32'd0);
        send_word(32'h0000_0793, 2);
        check("t4_addr", 32'(imem_addr), 32'd0);
        check("t4_wdata", imem_wdata, 32'h0000_0793);
        @(negedge clk);
        check("t4_count", 32'(word_count), 32'd1);

        // Reset between 2nd and 3rd byte
        do_reset();
        send_word(32'hCAFE_0001, 1);
        send_byte(8'h13, 1);
        send_byte(8'h01, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_count", 32'(word_count), 32'd0);
        check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t5_imem_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_word(32'h00A0_0093, 1);
        check("t5_we", 32'(imem_we), 32'd1);
        check("t5_addr", 32'(imem_addr), 32'd0);
        check("t5_wdata", imem_wdata, 32'h00A0_0093);

        // Memory fills: MAX_WORDS writes, the next word is ignored
        do_reset();
        for (int i = 0; i < P_MAX; i++) begin
            w = $urandom;
            w[31] = 1'b0;
            send_word(w, 1);
            check("t6_addr", 32'(imem_addr), 32'(i));
        end
        send_word(32'h0000_0013, 1);
        check("t6_no_we", 32'(imem_we), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd1);
        check("t6_done", 32'(write_done), 32'd1);
        check("t6_count", 32'(word_count), 32'(P_MAX));

        // Randomized streams against the model
        for (int run = 0; run < 25; run++) begin
            do_reset();
            bpos = 0;
            kind = 0;
            sel  = 0;
            for (int a = 0; a < $urandom_range(20, 60); a++) begin
                gap = ($urandom_range(0, 19) == 0) ? (P_TMO - 1 + $urandom_range(0, 2))
                                                   : $urandom_range(1, 6);
                if (bpos == 0) begin
                    kind = $urandom_range(0, 9);
                    sel  = $urandom_range(0, 3);
                end
                if (kind == 0) begin
                    d = 8'hFF;
                end else if (kind == 1) begin
                    d = (bpos == sel) ? 8'($urandom_range(0, 254)) : 8'hFF;
                end else begin
                    d = 8'($urandom);
                end
                r = $urandom_range(0, 99);
                if (r < 85) begin
                    send_byte(d, gap);
                    bpos = (bpos + 1) % 4;
                end else if (r < 92) begin
                    send_break(gap, 1'b0, d);
                    bpos = 0;
                end else if (r < 97) begin
                    send_break(gap, 1'b1, d);
                    bpos = 0;
                end else begin
                    repeat (gap) @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    bpos = 0;
                end
            end
            repeat (3) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Boot-time loader between the UART receiver and the instruction memory inside wrapper. It assembles received bytes, least-significant byte first, into 32-bit instruction words. Each word is written to consecutive instruction-memory addresses, and the CPU core is held in reset throughout. Loading ends on the terminator word 32'hFFFFFFFF or when memory is full; the block then asserts write_done and releases the core.

Parameters:
ADDR_W, 8, instruction-memory word-address width.
MAX_WORDS, 256, number of writable words; must be ≤ 2**ADDR_W.
TIMEOUT_CYC, 104170, idle clk cycles allowed between bytes of one word (20 bit-times at 9600 baud, 50 MHz clock) before the partial word is discarded.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
rx_valid  in  1  single-cycle pulse: rx_data holds a new byte.
rx_data  in  8  received byte.
rx_break  in  1  UART BREAK detected; level, sampled every cycle.
imem_we  out  1  instruction-memory write strobe, one cycle per word.
imem_addr  out  ADDR_W  word address for the write.
imem_wdata  out  32  assembled instruction word.
cpu_rst  out  1  core reset; high until loading completes.
write_done  out  1  loading complete; sticky until rst.
word_count  out  ADDR_W+1  number of words written so far.
overflow  out  1  loading stopped because memory filled; sticky.
sync_err  out  1  at least one partial word was dropped by timeout; sticky.

Behaviour:
- Reset (async, any state): state=COLLECT, byte_idx=0, addr=0, word register=0, timeout counter=0.
  - Outputs during reset: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, write_done=0, word_count=0, overflow=0, sync_err=0.
- All outputs are registered. Every state change happens on a rising edge of clk.
- COLLECT:
  - On rx_valid, rx_data is stored into word[8*byte_idx +: 8], byte_idx increments, and the timeout counter clears.
  - When the 4th byte arrives (rx_valid while byte_idx==3), byte_idx returns to 0 and the state goes to WRITE.
- Write latency: imem_we is high in the cycle immediately after the rx_valid of the 4th byte.
- WRITE (lasts exactly one cycle):
  - If word == 32'hFFFFFFFF: no write (imem_we=0); state goes to DONE.
  - Otherwise: imem_we=1, imem_addr=addr, imem_wdata=word. On the next edge, addr and word_count increment.
  - If addr == MAX_WORDS-1 at that point: overflow is set and the state goes to DONE. Otherwise the state returns to COLLECT.
- DONE:
  - write_done=1 and cpu_rst=0, both starting on the first cycle in DONE.
  - rx_valid and rx_break are ignored. The state is held until rst.
- Timeout:
  - In COLLECT with byte_idx≠0 and no rx_valid, the counter increments each cycle.
  - When it reaches TIMEOUT_CYC-1: byte_idx=0, counter=0, sync_err set. addr and word_count are unchanged.
  - While byte_idx==0, the counter is held at 0.
- rx_break (COLLECT or WRITE): restarts the load.
  - byte_idx=0, addr=0, word_count=0, counter=0, imem_we forced to 0 that cycle, next state COLLECT.
  - overflow and sync_err are not cleared.
  - rx_break takes priority over rx_valid in the same cycle.
- rx_valid arriving while in WRITE is dropped. The UART byte period (more than 5000 cycles) makes this impossible in normal operation.
- Terminator check covers the full 32 bits; 32'hFFFFFF00 etc. are written as normal data.
- Wrap-around: addr never wraps, because loading stops at MAX_WORDS. word_count can reach MAX_WORDS, which is why it is ADDR_W+1 bits wide.
- Reset asserted mid-word or in WRITE: the partial word is lost, no write strobe is issued, and all outputs return to their reset values asynchronously.

Test Plan:
- Bytes 13,01,01,FE then FF,FF,FF,FF → one imem_we pulse: addr 0, wdata 32'hFE010113, exactly 1 cycle after the 4th rx_valid. Then write_done=1, cpu_rst=0, word_count=1.
- Stream 3 words (32'h00812E23, 32'h02010413, 32'h001F7793) then terminator → writes at addr 0,1,2 in order; word_count=3; no write for the terminator.
- Bytes 93,77 then silence for TIMEOUT_CYC cycles, then 33,7F,FF,00 → sync_err=1; one write at addr 0, wdata 32'h00FF7F33.
- MAX_WORDS=4, five non-terminator words → 4 writes (addr 0..3); overflow=1, write_done=1; the 5th word produces no imem_we.
- After 2 words written, rx_break pulses mid-word, then word 32'h00000793 → written at addr 0; word_count=1.
- rst asserted between the 2nd and 3rd byte, then released → all outputs at reset values, cpu_rst=1. A full subsequent word is written at addr 0.
